// File: rtl/addsub_arbiter.sv
// Three-requester arbiter that shares one 34-bit add/sub datapath, one operation in flight.
// Define ADDSUB_ARB_FIXED_PRIO_EN for fixed priority 2 > 1 > 0; the default is round-robin.
module addsub_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  output logic [2:0]  req_ready,
  input  logic [2:0]  req_sub,
  input  logic [31:0] x0,
  input  logic [31:0] y0,
  input  logic [32:0] x1,
  input  logic [32:0] y1,
  input  logic [33:0] x2,
  input  logic [33:0] y2,
  output logic [2:0]  resp_valid,
  input  logic [2:0]  resp_ready,
  output logic [33:0] result,
  output logic        cout,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  own_q, own_d;
  logic        sub_q, sub_d;
  logic [33:0] x_q, x_d;
  logic [33:0] y_q, y_d;
  logic [33:0] result_q, result_d;
  logic        cout_q, cout_d;
  logic [34:0] sum;
  logic        gnt_vld;
  logic [1:0]  gnt_idx;

  function automatic logic sel3(input logic [2:0] v, input logic [1:0] i);
    case (i)
      2'd0:    sel3 = v[0];
      2'd1:    sel3 = v[1];
      2'd2:    sel3 = v[2];
      default: sel3 = 1'b0;
    endcase
  endfunction

  // Sum is formed on w+1 bits at the owner's width w; returns {carry, zero-extended result}.
  function automatic logic [34:0] addsub_f(input logic [33:0] x, input logic [33:0] y,
                                           input logic sub, input logic [1:0] idx);
    logic [32:0] s0;
    logic [33:0] s1;
    logic [34:0] s2;
    s0 = {1'b0, x[31:0]} + {1'b0, y[31:0] ^ {32{sub}}} + {32'd0, sub};
    s1 = {1'b0, x[32:0]} + {1'b0, y[32:0] ^ {33{sub}}} + {33'd0, sub};
    s2 = {1'b0, x} + {1'b0, y ^ {34{sub}}} + {34'd0, sub};
    case (idx)
      2'd0:    addsub_f = {s0[32], 2'b00, s0[31:0]};
      2'd1:    addsub_f = {s1[33], 1'b0, s1[32:0]};
      default: addsub_f = s2;
    endcase
  endfunction

`ifdef ADDSUB_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_vld = |req_valid;
    gnt_idx = 2'd0;
    if (req_valid[2])      gnt_idx = 2'd2;
    else if (req_valid[1]) gnt_idx = 2'd1;
  end
`else
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] cand;

  function automatic logic [1:0] inc3(input logic [1:0] i);
    case (i)
      2'd0:    inc3 = 2'd1;
      2'd1:    inc3 = 2'd2;
      default: inc3 = 2'd0;
    endcase
  endfunction

  // Search starts at the pointer and wraps modulo 3.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    cand    = ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (!gnt_vld && sel3(req_valid, cand)) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
      cand = inc3(cand);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && gnt_vld) ptr_d = inc3(gnt_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 2'd0;
    else     ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    sub_d     = sub_q;
    x_d       = x_q;
    y_d       = y_q;
    result_d  = result_q;
    cout_d    = cout_q;
    req_ready = 3'b000;
    sum       = '0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          req_ready = 3'b001 << gnt_idx;
          own_d     = gnt_idx;
          sub_d     = sel3(req_sub, gnt_idx);
          state_d   = EXEC;
          case (gnt_idx)
            2'd0: begin
              x_d = {2'b00, x0};
              y_d = {2'b00, y0};
            end
            2'd1: begin
              x_d = {1'b0, x1};
              y_d = {1'b0, y1};
            end
            default: begin
              x_d = x2;
              y_d = y2;
            end
          endcase
        end
      end
      EXEC: begin
        sum      = addsub_f(x_q, y_q, sub_q, own_q);
        result_d = sum[33:0];
        cout_d   = sum[34];
        state_d  = RESP;
      end
      RESP: begin
        if (sel3(resp_ready, own_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset wins over a grant that would otherwise be signalled this cycle.
    if (rst) req_ready = 3'b000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      own_q    <= 2'd0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  // Operand capture holds only data and needs no reset.
  always_ff @(posedge clk) begin
    x_q   <= x_d;
    y_q   <= y_d;
    sub_q <= sub_d;
  end

  assign resp_valid = (state_q == RESP) ? (3'b001 << own_q) : 3'b000;
  assign busy       = (state_q != IDLE);
  assign result     = result_q;
  assign cout       = cout_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: transaction-level reference model checked every cycle, plus directed literals.
module tb_addsub_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid, req_ready, req_sub;
  logic [31:0] x0, y0;
  logic [32:0] x1, y1;
  logic [33:0] x2, y2;
  logic [2:0]  resp_valid, resp_ready;
  logic [33:0] result;
  logic        cout, busy;

  int n_tests = 0;
  int n_fail  = 0;

  addsub_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .result(result), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int pick(input logic [2:0] v, input int p);
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
    if (v[2]) return 2;
    if (v[1]) return 1;
    return 0;
`else
    for (int k = 0; k < 3; k++)
      if (v[(p + k) % 3]) return (p + k) % 3;
    return 0;
`endif
  endfunction

  task automatic exp_calc(input int g, input bit sub, input longint unsigned xi,
                          input longint unsigned yi, output longint unsigned r, output bit c);
    longint unsigned m, x, y;
    m = (64'd1 << (32 + g)) - 64'd1;
    x = xi & m;
    y = yi & m;
    if (sub) begin
      r = (x - y) & m;
      c = (x >= y);
    end else begin
      r = (x + y) & m;
      c = ((x + y) >> (32 + g)) != 0;
    end
  endtask

  int              m_phase = 0;  // 0 waiting, 1 computing, 2 answering
  int              m_own   = 0;
  int              m_ptr   = 0;
  longint unsigned m_res   = 0;
  bit              m_cout  = 1'b0;
  bit              m_on    = 1'b0;

  always @(posedge clk) begin : model
    int              g;
    longint unsigned r, xs, ys;
    bit              c;
    if (rst) begin
      m_phase <= 0;
      m_ptr   <= 0;
      m_on    <= 1'b1;
    end else if (m_on) begin
      case (m_phase)
        0: if (|req_valid) begin
          g = pick(req_valid, m_ptr);
          case (g)
            0:       begin xs = 64'(x0); ys = 64'(y0); end
            1:       begin xs = 64'(x1); ys = 64'(y1); end
            default: begin xs = 64'(x2); ys = 64'(y2); end
          endcase
          exp_calc(g, req_sub[g], xs, ys, r, c);
          m_own   <= g;
          m_res   <= r;
          m_cout  <= c;
          m_ptr   <= (g + 1) % 3;
          m_phase <= 1;
        end
        1:       m_phase <= 2;
        default: if (resp_ready[m_own]) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin : compare
    logic [2:0] exp_rdy, exp_rv;
    if (m_on) begin
      exp_rdy = 3'b000;
      if (!rst && m_phase == 0 && |req_valid) exp_rdy = 3'b001 << pick(req_valid, m_ptr);
      exp_rv = (m_phase == 2) ? (3'b001 << m_own) : 3'b000;
      chk("m_req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("m_resp_valid", 64'(resp_valid), 64'(exp_rv));
      chk("m_busy", 64'(busy), 64'(m_phase != 0));
      if (m_phase == 2) begin
        chk("m_result", 64'(result), m_res);
        chk("m_cout", 64'(cout), 64'(m_cout));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input int g, input logic [33:0] x, input logic [33:0] y, input bit sub);
    case (g)
      0:       begin x0 = x[31:0]; y0 = y[31:0]; end
      1:       begin x1 = x[32:0]; y1 = y[32:0]; end
      default: begin x2 = x;       y2 = y;       end
    endcase
    req_sub    = 3'b000;
    req_sub[g] = sub;
  endtask

  task automatic finish_resp(input int g, input string nm);
    int lat;
    lat = 0;
    @(negedge clk);
    while (!resp_valid[g] && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_resp"}, 64'(resp_valid[g]), 64'd1);
    @(posedge clk); #1 resp_ready = 3'b001 << g;
    @(posedge clk); #1 resp_ready = 3'b000;
  endtask

  task automatic run_op(input int g, input bit sub, input logic [33:0] x, input logic [33:0] y,
                        input logic [33:0] er, input bit ec, input string nm);
    int cyc, lat;
    drive(g, x, y, sub);
    req_valid = 3'b001 << g;
    cyc = 0;
    @(negedge clk);
    while (!req_ready[g] && cyc < 5) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_accept"}, 64'(req_ready[g]), 64'd1);
    @(posedge clk); #1 req_valid = 3'b000;
    lat = 1;
    @(negedge clk);
    while (!resp_valid[g] && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd2);
    chk({nm, "_result"}, 64'(result), 64'(er));
    chk({nm, "_cout"}, 64'(cout), 64'(ec));
    @(posedge clk); #1 resp_ready = 3'b001 << g;
    @(posedge clk); #1 resp_ready = 3'b000;
  endtask

  function automatic int idx_of(input logic [2:0] v);
    if (v[0]) return 0;
    if (v[1]) return 1;
    return 2;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int order[3];
    int ng, first_g, exp_first;
    rst = 1'b1; req_valid = 3'b000; req_sub = 3'b000; resp_ready = 3'b000;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;

    run_op(0, 1'b0, 34'd578, 34'd678, 34'd1256, 1'b0, "add0");
    run_op(1, 1'b1, 34'd10, 34'd15, 34'h1_FFFF_FFFB, 1'b0, "sub1_borrow");
    run_op(1, 1'b1, 34'd15, 34'd10, 34'd5, 1'b1, "sub1_ok");
    run_op(2, 1'b0, 34'h3_FFFF_FFFF, 34'd1, 34'd0, 1'b1, "carry2");
    run_op(0, 1'b0, 34'h0_FFFF_FFFF, 34'd1, 34'd0, 1'b1, "carry0");
    run_op(2, 1'b1, 34'd5, 34'd5, 34'd0, 1'b1, "sub2_eq");

    // Backpressure with non-owner resp_ready bits high and another requester waiting.
    drive(1, 34'h1_0000_0005, 34'h1_0000_0003, 1'b0);
    x0 = 32'd7; y0 = 32'd9;
    req_valid = 3'b010; resp_ready = 3'b101;
    @(negedge clk);
    chk("bp_accept", 64'(req_ready), 64'b010);
    @(posedge clk); #1 req_valid = 3'b001;
    @(negedge clk);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_resp_valid", 64'(resp_valid), 64'b010);
      chk("bp_result", 64'(result), 64'd8);
      chk("bp_cout", 64'(cout), 64'd1);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
    end
    resp_ready = 3'b010;
    @(posedge clk); #1 resp_ready = 3'b000;
    @(negedge clk);
    chk("bp_release_busy", 64'(busy), 64'd0);
    chk("bp_next_grant", 64'(req_ready), 64'b001);
    @(posedge clk); #1 req_valid = 3'b000;
    finish_resp(0, "bp_next");

    // Contention from reset with every requester valid.
    x0 = 32'd100; y0 = 32'd1; x1 = 33'd50; y1 = 33'd60; x2 = 34'd3; y2 = 34'd4;
    req_sub = 3'b010; resp_ready = 3'b111; req_valid = 3'b111;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    ng = 0;
    for (int c = 0; c < 40 && ng < 3; c++) begin
      @(negedge clk);
      if (|req_ready) begin
        order[ng] = idx_of(req_ready);
        ng++;
      end
      @(posedge clk); #1;
    end
    req_valid = 3'b000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    @(posedge clk); #1 resp_ready = 3'b000;
    chk("cont_count", 64'(ng), 64'd3);
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
    chk("cont_g0", 64'(order[0]), 64'd2);
    chk("cont_g1", 64'(order[1]), 64'd1);
    chk("cont_g2", 64'(order[2]), 64'd0);
    exp_first = 2;
`else
    chk("cont_g0", 64'(order[0]), 64'd0);
    chk("cont_g1", 64'(order[1]), 64'd1);
    chk("cont_g2", 64'(order[2]), 64'd2);
    exp_first = 0;
`endif

    // Reset during EXEC abandons the operation and restores the pointer.
    drive(1, 34'd20, 34'd22, 1'b0);
    req_valid = 3'b010;
    @(negedge clk);
    chk("mid_accept", 64'(req_ready), 64'b010);
    @(posedge clk); #1 req_valid = 3'b000; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_resp_valid", 64'(resp_valid), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_result", 64'(result), 64'd0);
    @(posedge clk); #1 req_valid = 3'b111;
    @(negedge clk);
    first_g = idx_of(req_ready);
    chk("mid_first_grant", 64'(first_g), 64'(exp_first));
    @(posedge clk); #1 req_valid = 3'b000;
    finish_resp(first_g, "mid_after");
    run_op(1, 1'b0, 34'd20, 34'd22, 34'd42, 1'b0, "post_rst");

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameters: none; operand widths fixed at 32/33/34 bits for requesters 0/1/2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  3  bit i = requester i has an operation pending.
REQ-005 req_ready  output  3  bit i = requester i's operation accepted this cycle.
REQ-006 req_sub  input  3  bit i: 1 = subtract (X-Y), 0 = add (X+Y).
REQ-007 x0, y0  input  32 each  requester 0 operands (ALU path).
REQ-008 x1, y1  input  33 each  requester 1 operands (divider path).
REQ-009 x2, y2  input  34 each  requester 2 operands (multiplier path).
REQ-010 resp_valid  output  3  bit i = result for requester i available.
REQ-011 resp_ready  input  3  bit i = requester i consumes result.
REQ-012 result  output  34  shared result bus, meaningful only while some resp_valid bit is high.
REQ-013 cout  output  1  carry-out at owner's width, valid with resp_valid.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The block SHALL own one 34-bit add/sub datapath and SHALL allow at most one operation in flight.
REQ-016 FSM states SHALL be IDLE, EXEC, RESP.
REQ-017 IDLE: if any req_valid is high, grant exactly one requester g, drive req_ready[g]=1 for that cycle only, capture its operands, sub bit and index, go to EXEC; otherwise stay IDLE.
REQ-018 req_ready SHALL be zero in EXEC and RESP, and at most one bit SHALL be high in any cycle.
REQ-019 EXEC (exactly one cycle): compute S = X + (Y XOR {w{sub}}) + sub on w+1 bits with X, Y zero-extended, w = owner width; register result = S[w-1:0] zero-extended to 34 bits and cout = S[w]; go to RESP.
REQ-020 RESP: hold resp_valid[g]=1, result, cout stable until resp_ready[g]=1; in that cycle go to IDLE; resp_ready bits of non-owners SHALL be ignored.
REQ-021 Latency: accept in cycle N -> resp_valid high from cycle N+2; next acceptance no earlier than the cycle after the response handshake.
REQ-022 Subtract cout SHALL equal 1 when X >= Y (no borrow), 0 otherwise.
REQ-023 Arbitration (default) SHALL be round-robin: pointer p starts at 0; search order p, p+1, p+2 mod 3; after granting g, p := (g+1) mod 3.
REQ-024 A requester deasserting req_valid before being granted SHALL not be granted; operands SHALL be sampled only in the grant cycle.
REQ-025 Simultaneous requests from all three SHALL be served in three consecutive transactions with no requester served twice.

Reset
REQ-026 On rst high at a clock edge: state := IDLE, p := 0, req_ready = 0, resp_valid = 0, result = 0, cout = 0, busy = 0.
REQ-027 Reset in EXEC or RESP SHALL abandon the operation with no response issued; rst SHALL override all other inputs that cycle.

Configuration
REQ-028 Macro ADDSUB_ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority 2 > 1 > 0 and the pointer SHALL not exist; when undefined, round-robin per REQ-023.

Verification
REQ-029 Single add: req 0, x0=578, y0=678, sub=0 -> req_ready[0] in accept cycle, two cycles later resp_valid[0]=1, result=1256, cout=0.
REQ-030 Subtract borrow: req 1, x1=10, y1=15, sub=1 -> result=0x1_FFFF_FFFB (33-bit), cout=0; x1=15, y1=10 -> result=5, cout=1.
REQ-031 Width carry: req 2, x2=0x3_FFFF_FFFF, y2=1, add -> result=0, cout=1; req 0 with x0=0xFFFF_FFFF, y0=1 -> result=0, cout=1.
REQ-032 Contention: all three valid continuously from reset -> grants 0,1,2 (round-robin); with ADDSUB_ARB_FIXED_PRIO_EN -> grant order 2,1,0.
REQ-033 Backpressure: hold resp_ready[g]=0 for 5 cycles -> resp_valid, result, cout stable, req_ready stays 0, busy=1; release -> IDLE next cycle.
REQ-034 Reset mid-op: assert rst in EXEC -> next cycle resp_valid=0, busy=0, pointer=0; subsequent request completes normally.
